// File: rtl/event_recorder_pkg.sv
// Shared types and record layout for the event recorder.
// Record layout, MSB first: {timestamp, peak, area, incomplete}.
package event_recorder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PEAK,
    S_WAIT_AREA,
    S_COMMIT
  } ev_state_t;

  localparam int N_P_DEF = 12;
  localparam int N_A_DEF = 20;
  localparam int N_T_DEF = 32;

  localparam int OFF_INC  = 0;
  localparam int OFF_AREA = 1;

  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  function automatic int rec_width(input int n_t, input int n_p, input int n_a);
    return n_t + n_p + n_a + 1;
  endfunction

  function automatic int off_peak(input int n_a);
    return OFF_AREA + n_a;
  endfunction

  function automatic int off_ts(input int n_p, input int n_a);
    return OFF_AREA + n_a + n_p;
  endfunction

  localparam int REC_W_DEF = rec_width(N_T_DEF, N_P_DEF, N_A_DEF);

endpackage

// File: rtl/event_recorder_if.sv
// Readout handshake carrying event records from the recorder to its consumer.
interface event_recorder_if #(
  parameter int W = event_recorder_pkg::REC_W_DEF
);
  logic [W-1:0] ev_data;
  logic         ev_valid;
  logic         ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/event_recorder_fifo.sv
// First-word-fall-through record FIFO; pushes when full and pops when empty are ignored.
module event_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign count  = r_count;
  // Head is forced to zero when empty so the bus reads 0 out of reset.
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/event_recorder.sv
// Timestamps detector pulses, collects peak and area into one record and queues it.
// state       | meaning
// S_IDLE      | waiting for a posedge_flag rise with enable high
// S_WAIT_PEAK | event open, waiting for the final peak (area may arrive first)
// S_WAIT_AREA | peak held, waiting for the area
// S_COMMIT    | one cycle: write the record or count it as dropped
module event_recorder
  import event_recorder_pkg::*;
#(
  parameter int N_P        = 12,
  parameter int N_A        = 20,
  parameter int N_T        = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int EV_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear_counters,
  input  logic                          posedge_flag,
  input  logic                          top_value_flag,
  input  logic signed [N_P-1:0]         peak_value,
  input  logic                          area_ready,
  input  logic signed [N_A-1:0]         area_value,
  event_recorder_if.master              ev_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   overflow_count,
  output logic                          busy
);
  localparam int W  = rec_width(N_T, N_P, N_A);
  localparam int TW = $clog2(EV_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(EV_TIMEOUT);

  ev_state_t              r_state;
  logic [N_T-1:0]         r_ts;
  logic [N_T-1:0]         r_ts_lat;
  logic signed [N_P-1:0]  r_peak;
  logic signed [N_A-1:0]  r_area;
  logic                   r_inc;
  logic                   r_area_seen;
  logic [TW-1:0]          r_tmo;
  logic                   r_busy;
  logic [15:0]            r_ovf;
  logic                   r_pos_old;
  logic                   r_top_old;
  logic                   r_area_old;

  logic                   w_pos_rise;
  logic                   w_top_rise;
  logic                   w_area_rise;
  logic                   w_commit;
  logic                   w_full;
  logic                   w_empty;
  logic [W-1:0]           w_rec;
  logic [W-1:0]           w_rdata;

  assign w_pos_rise  = posedge_flag & ~r_pos_old;
  assign w_top_rise  = top_value_flag & ~r_top_old;
  assign w_area_rise = area_ready & ~r_area_old;
  assign w_commit    = (r_state == S_COMMIT);

  always_comb begin
    w_rec = '0;
    w_rec[OFF_INC]                = r_inc;
    w_rec[OFF_AREA +: N_A]        = r_area;
    w_rec[off_peak(N_A) +: N_P]   = r_peak;
    w_rec[off_ts(N_P, N_A) +: N_T] = r_ts_lat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts       <= '0;
      r_ovf      <= '0;
      r_pos_old  <= 1'b0;
      r_top_old  <= 1'b0;
      r_area_old <= 1'b0;
    end else begin
      r_pos_old  <= posedge_flag;
      r_top_old  <= top_value_flag;
      r_area_old <= area_ready;
      r_ts       <= clear_counters ? '0 : r_ts + N_T'(1);
      // A clear in the same cycle as a dropped record still leaves zero.
      if (clear_counters)
        r_ovf <= '0;
      else if (w_commit && w_full && (r_ovf != OVF_MAX))
        r_ovf <= r_ovf + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ts_lat    <= '0;
      r_peak      <= '0;
      r_area      <= '0;
      r_inc       <= 1'b0;
      r_area_seen <= 1'b0;
      r_tmo       <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pos_rise && enable) begin
            r_ts_lat    <= r_ts;
            r_peak      <= '0;
            r_area      <= '0;
            r_inc       <= 1'b0;
            r_area_seen <= 1'b0;
            r_tmo       <= TMO_LOAD;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT_PEAK;
          end
        end
        S_WAIT_PEAK: begin
          // Terminal count means EV_TIMEOUT cycles spent waiting; it wins over captures.
          if (r_tmo == TW'(1)) begin
            r_inc   <= 1'b1;
            r_state <= S_COMMIT;
          end else begin
            r_tmo <= r_tmo - TW'(1);
            if (w_area_rise && !r_area_seen) begin
              r_area      <= area_value;
              r_area_seen <= 1'b1;
            end
            if (w_top_rise) begin
              r_peak  <= peak_value;
              r_state <= (w_area_rise || r_area_seen) ? S_COMMIT : S_WAIT_AREA;
            end
          end
        end
        S_WAIT_AREA: begin
          if (r_tmo == TW'(1)) begin
            r_inc   <= 1'b1;
            r_state <= S_COMMIT;
          end else begin
            r_tmo <= r_tmo - TW'(1);
            if (w_area_rise || r_area_seen) begin
              if (!r_area_seen) begin
                r_area      <= area_value;
                r_area_seen <= 1'b1;
              end
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  event_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_commit),
    .wdata (w_rec),
    .full  (w_full),
    .pop   (ev_if.ev_ready),
    .rdata (w_rdata),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign ev_if.ev_data  = w_rdata;
  assign ev_if.ev_valid = ~w_empty;
  assign overflow_count = r_ovf;
  assign busy           = r_busy;

endmodule

// File: tb/tb_event_recorder.sv
// Bench for event_recorder: directed scenarios plus random events against a record-level model.
module tb_event_recorder;
  localparam int N_P   = 12;
  localparam int N_A   = 20;
  localparam int N_T   = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;
  localparam int W     = N_T + N_P + N_A + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clear_counters = 1'b0;
  logic posedge_flag = 1'b0;
  logic top_value_flag = 1'b0;
  logic area_ready = 1'b0;
  logic signed [N_P-1:0] peak_value = '0;
  logic signed [N_A-1:0] area_value = '0;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_count;
  logic        busy;

  event_recorder_if #(.W(W)) ev_if ();

  event_recorder #(
    .N_P(N_P), .N_A(N_A), .N_T(N_T), .FIFO_DEPTH(DEPTH), .EV_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_counters(clear_counters),
    .posedge_flag(posedge_flag), .top_value_flag(top_value_flag),
    .peak_value(peak_value), .area_ready(area_ready), .area_value(area_value),
    .ev_if(ev_if), .fifo_count(fifo_count), .overflow_count(overflow_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N_T-1:0] tb_ts = '0;
  int tb_cnt = 0;
  int tb_ovf = 0;
  logic [W-1:0] sb[$];
  bit commit_now = 0;
  logic [W-1:0] commit_rec = '0;
  bit rand_ready = 0;

  // One clock edge: check the DUT against the model, then advance the model across the edge.
  task automatic tick();
    int pre;
    bit do_push, do_pop;
    if (rand_ready) ev_if.ev_ready = ($urandom_range(0, 3) != 0);
    pre = tb_cnt;
    n_tests++;
    if (ev_if.ev_valid !== (pre > 0)) begin
      n_fail++; $display("FAIL ev_valid: got %b expected %b", ev_if.ev_valid, (pre > 0));
    end
    n_tests++;
    if (fifo_count !== 5'(pre)) begin
      n_fail++; $display("FAIL fifo_count: got %0d expected %0d", fifo_count, pre);
    end
    n_tests++;
    if (overflow_count !== 16'(tb_ovf)) begin
      n_fail++; $display("FAIL overflow_count: got %0d expected %0d", overflow_count, tb_ovf);
    end
    if (pre > 0) begin
      n_tests++;
      if (ev_if.ev_data !== sb[0]) begin
        n_fail++; $display("FAIL ev_data head: got %h expected %h", ev_if.ev_data, sb[0]);
      end
    end
    do_push = commit_now && (pre < DEPTH);
    do_pop  = (ev_if.ev_ready === 1'b1) && (pre > 0);
    if (do_push) sb.push_back(commit_rec);
    if (do_pop) void'(sb.pop_front());
    if (clear_counters) tb_ovf = 0;
    else if (commit_now && !do_push && tb_ovf < 65535) tb_ovf++;
    tb_cnt = pre + int'(do_push) - int'(do_pop);
    tb_ts = clear_counters ? '0 : tb_ts + 1;
    commit_now = 0;
    @(posedge clk); #1;
  endtask

  // dp/da: edge offset after the start edge at which each flag rise is seen (0 = never).
  task automatic do_event(input int dp, input int da, input logic signed [N_P-1:0] pk,
                          input logic signed [N_A-1:0] ar, input bit clr);
    logic [N_T-1:0] ts_lat;
    logic signed [N_P-1:0] ep;
    logic signed [N_A-1:0] ea;
    bit pc, ac;
    int c;
    pc = (dp >= 1) && (dp <= TMO - 1);
    ac = (da >= 1) && (da <= TMO - 1);
    c  = (pc && ac) ? ((dp > da) ? dp : da) : TMO;
    ep = pc ? pk : '0;
    ea = ac ? ar : '0;
    peak_value = pk;
    area_value = ar;
    ts_lat = tb_ts;
    posedge_flag = 1'b1;
    tick();
    posedge_flag = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    for (int k = 1; k <= c; k++) begin
      top_value_flag = (k == dp);
      area_ready     = (k == da);
      tick();
    end
    top_value_flag = 1'b0;
    area_ready     = 1'b0;
    commit_rec = {ts_lat, ep, ea, !(pc && ac)};
    commit_now = 1;
    clear_counters = clr;
    tick();
    clear_counters = 1'b0;
  endtask

  task automatic drain();
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && tb_cnt > 0; i++) tick();
    ev_if.ev_ready = 1'b0;
    n_tests++;
    if (fifo_count !== 5'd0) begin
      n_fail++; $display("FAIL drain: fifo_count got %0d expected 0", fifo_count);
    end
  endtask

  task automatic test_reset();
    ev_if.ev_ready = 1'b0;
    #3 reset = 1'b0;
    #5;
    n_tests++;
    if ({ev_if.ev_valid, busy, fifo_count, overflow_count} !== '0 || ev_if.ev_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b busy=%b cnt=%0d ovf=%0d data=%h expected all 0",
               ev_if.ev_valid, busy, fifo_count, overflow_count, ev_if.ev_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tb_ts = '0; tb_cnt = 0; tb_ovf = 0; sb.delete();
    enable = 1'b1;
  endtask

  task automatic test_nominal();
    logic [W-1:0] exp;
    for (int i = 0; i < 200 && tb_ts != 100; i++) tick();
    do_event(2, 3, 12'sd850, 20'sd4321, 0);
    exp = {32'd100, 12'sd850, 20'sd4321, 1'b0};
    n_tests++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp) begin
      n_fail++; $display("FAIL nominal_record: got %h (valid %b) expected %h", ev_if.ev_data, ev_if.ev_valid, exp);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL nominal_busy_idle: got %b expected 0", busy);
    end
    drain();
  endtask

  task automatic test_enable_gate();
    enable = 1'b0;
    posedge_flag = 1'b1;
    tick();
    posedge_flag = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL enable_gate_busy: got %b expected 0", busy);
    end
    top_value_flag = 1'b1; area_ready = 1'b1;
    tick();
    top_value_flag = 1'b0; area_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [N_T-1:0] t0;
    logic [W-1:0] exp;
    t0 = tb_ts;
    do_event(2, 2, -12'sd5, -20'sd300, 0);
    exp = {t0, -12'sd5, -20'sd300, 1'b0};
    n_tests++;
    if (ev_if.ev_data !== exp) begin
      n_fail++; $display("FAIL simultaneous_record: got %h expected %h", ev_if.ev_data, exp);
    end
    drain();
  endtask

  task automatic test_timeout();
    logic [N_T-1:0] t0;
    logic [W-1:0] exp;
    t0 = tb_ts;
    do_event(0, 0, 12'sd77, 20'sd99, 0);
    exp = {t0, 12'd0, 20'd0, 1'b1};
    n_tests++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp) begin
      n_fail++; $display("FAIL timeout_record: got %h (valid %b) expected %h", ev_if.ev_data, ev_if.ev_valid, exp);
    end
    drain();
    t0 = tb_ts;
    do_event(3, 0, 12'sd123, 20'sd55, 0);
    exp = {t0, 12'sd123, 20'd0, 1'b1};
    n_tests++;
    if (ev_if.ev_data !== exp) begin
      n_fail++; $display("FAIL timeout_partial: got %h expected %h", ev_if.ev_data, exp);
    end
    drain();
  endtask

  logic [W-1:0] head;

  task automatic test_overflow();
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      do_event(1, 2, 12'($urandom), 20'($urandom), 0);
    head = sb[0];
    for (int i = 0; i < 3; i++)
      do_event(2, 1, 12'($urandom), 20'($urandom), 0);
    n_tests++;
    if (fifo_count !== 5'd16 || overflow_count !== 16'd3) begin
      n_fail++; $display("FAIL overflow_counts: cnt=%0d ovf=%0d expected 16 and 3", fifo_count, overflow_count);
    end
    n_tests++;
    if (ev_if.ev_data !== head) begin
      n_fail++; $display("FAIL overflow_head: got %h expected %h", ev_if.ev_data, head);
    end
  endtask

  task automatic test_backpressure_clear();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (ev_if.ev_data !== head) begin
        n_fail++; $display("FAIL backpressure_stable: got %h expected %h", ev_if.ev_data, head);
      end
    end
    do_event(1, 1, 12'sd1, 20'sd1, 1);
    n_tests++;
    if (overflow_count !== 16'd0) begin
      n_fail++; $display("FAIL clear_wins: overflow_count got %0d expected 0", overflow_count);
    end
    drain();
  endtask

  task automatic test_random();
    int dp, da;
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: dp = 0;
        1: dp = TMO + 3;
        default: dp = $urandom_range(1, TMO - 1);
      endcase
      case ($urandom_range(0, 5))
        0: da = 0;
        1: da = TMO + 3;
        default: da = $urandom_range(1, TMO - 1);
      endcase
      do_event(dp, da, 12'($urandom), 20'($urandom), 0);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    rand_ready = 0;
    drain();
  endtask

  task automatic test_reset_mid();
    ev_if.ev_ready = 1'b0;
    do_event(1, 1, 12'sd9, 20'sd9, 0);
    posedge_flag = 1'b1; tick(); posedge_flag = 1'b0;
    peak_value = 12'sd7;
    top_value_flag = 1'b1; tick(); top_value_flag = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    n_tests++;
    if ({ev_if.ev_valid, busy, fifo_count, overflow_count} !== '0 || ev_if.ev_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_values: valid=%b busy=%b cnt=%0d ovf=%0d data=%h expected all 0",
               ev_if.ev_valid, busy, fifo_count, overflow_count, ev_if.ev_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tb_ts = '0; tb_cnt = 0; tb_ovf = 0; sb.delete();
    area_value = 20'sd5;
    area_ready = 1'b1; tick(); area_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_enable_gate();
    test_simultaneous();
    test_timeout();
    test_overflow();
    test_backpressure_clear();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_recorder.md
# event_recorder

Downstream stage of the peak/area detector. Timestamps each detected pulse on its threshold crossing, collects the peak value and the integrated area, and packs them into one event record. Records go into a first-word-fall-through FIFO drained through a valid/ready handshake, for the readout/UART path. Events that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- N_P, 12, peak width (signed)
- N_A, 20, area width (signed)
- N_T, 32, timestamp width (unsigned)
- FIFO_DEPTH, 16, records; power of two, ≥2
- EV_TIMEOUT, 1023, max clk cycles from event start to area capture

Ports (W = N_T+N_P+N_A+1):
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows new events to start.
- clear_counters  in  1  synchronous clear of the timestamp and overflow_count.
- posedge_flag  in  1  detector: pulse started.
- top_value_flag  in  1  detector: peak final.
- peak_value  in  N_P  detector peak.
- area_ready  in  1  detector: area valid.
- area_value  in  N_A  detector area.
- ev_data  out  W  record {timestamp, peak, area, incomplete}; MSB first.
- ev_valid  out  1  FIFO head is valid.
- ev_ready  in  1  consumer accepts the head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  stored records.
- overflow_count  out  16  dropped events; saturates at 16'hFFFF.
- busy  out  1  FSM not in IDLE.

## Operation
- Free-running timestamp increments every clk and wraps modulo 2^N_T.
- Edge detection: each flag is registered once (`*_old`, reset to 0). A rise is `flag & !flag_old`, evaluated in the same cycle the flag is seen.

FSM states: IDLE, WAIT_PEAK, WAIT_AREA, COMMIT.
- IDLE:
  - Rise of posedge_flag with enable=1: latch timestamp. Clear peak, area, incomplete and the timeout counter. Go to WAIT_PEAK.
  - Rise with enable=0: ignored.
- WAIT_PEAK:
  - Rise of top_value_flag: latch peak_value, go to WAIT_AREA.
  - Rise of area_ready in the same cycle or earlier: also latch area_value and set area_seen. If both peak and area are then held, go directly to COMMIT.
- WAIT_AREA:
  - Rise of area_ready, or area_seen already set: latch area_value (unless already held), go to COMMIT.
- Timeout: the counter runs in WAIT_PEAK and WAIT_AREA. When it reaches EV_TIMEOUT, set incomplete=1 and go to COMMIT. Any field not captured stays 0.
- COMMIT (one cycle):
  - FIFO not full: write the record.
  - FIFO full: no write; overflow_count increments (saturating).
  - Then go to IDLE.
- A rise of posedge_flag in any state other than IDLE is ignored; there is no nested event.
- enable falling mid-event does not abort the event.
- FIFO fullness is judged on the pre-pop count. A pop in the same cycle as COMMIT does not make room; the write is dropped and counted.
- clear_counters and an overflow increment in the same cycle: the clear wins.

## Timing
- Reset (reset=0, async) values:
  - ev_valid=0, ev_data=0, fifo_count=0, overflow_count=0, busy=0.
  - timestamp=0, FSM=IDLE, FIFO emptied.
- Reset mid-event discards the partial record.
- busy rises on the clk edge after the posedge_flag rise.
- The COMMIT write lands on the COMMIT edge. ev_valid is high from the next cycle; ev_data is stable while ev_valid=1 and ev_ready=0.
- A pop occurs on any edge with ev_valid & ev_ready. The next record (if any) is presented in the following cycle with no bubble.
- Typical latency from area_ready rise to ev_valid: 2 clk (WAIT_AREA→COMMIT→visible).
- The latched timestamp equals the counter value in the cycle the posedge_flag rise is seen.

## Structure
- Package event_recorder_pkg:
  - state enum ev_state_t.
  - localparams for record field offsets and widths, derived from N_T/N_P/N_A.
  - OVF_MAX constant.
- Sub-module event_fifo, parameterised WIDTH and DEPTH:
  - synchronous FWFT with async active-low reset;
  - push/full/pop/empty/count;
  - ignores a push when full and a pop when empty.
- Top level holds the edge detectors, timestamp, FSM, latches and overflow counter.

## Test plan
- Nominal event: posedge_flag rises at timestamp 100, top rises with peak 12'sd850, area_ready rises 1 cycle later with area 20'sd4321. Expect ev_data={32'd100, 850, 4321, 0}, with ev_valid rising 2 cycles after the area_ready rise.
- Simultaneous top_value_flag and area_ready rise. Expect a direct WAIT_PEAK→COMMIT transition and a correct record. Negative values (peak −5, area −300) are preserved in two's complement.
- Timeout: with EV_TIMEOUT=20, never assert top_value_flag. Expect a record with peak=0, area=0, incomplete=1, written 21 cycles after start.
- Overflow: fill 16 records with ev_ready=0, then send 3 more events. Expect fifo_count=16, overflow_count=3, and the head unchanged. Then pop all 16 in order with ev_ready held at 1.
- Back-pressure plus clear: hold ev_ready=0 and check ev_data stays stable. Assert clear_counters in the same cycle as an overflow and expect overflow_count=0. Assert reset mid-WAIT_AREA and expect all outputs at reset values and no record produced.
